// File: rtl/fir_pkg.sv
// Shared FIR datapath constants: default widths, saturation bounds and output buffer depth.
package fir_pkg;

    localparam int unsigned NB_INPUT_DEF  = 12;
    localparam int unsigned NB_OUTPUT_DEF = 8;
    localparam int          SAT_MAX_DEF   = int'(2 ** (NB_OUTPUT_DEF - 1)) - 1;
    localparam int          SAT_MIN_DEF   = -SAT_MAX_DEF - 1;
    localparam int unsigned FIFO_DEPTH    = 2;

endpackage

// File: rtl/fir_sat_round.sv
// Combinational requantizer: drops NB_INPUT-NB_OUTPUT LSBs and saturates to NB_OUTPUT bits.
// Round half-up is enabled by defining FIR_DEC_ROUND_EN; otherwise the shift truncates.
module fir_sat_round
    import fir_pkg::*;
#(
    parameter int unsigned NB_INPUT  = NB_INPUT_DEF,
    parameter int unsigned NB_OUTPUT = NB_OUTPUT_DEF,
    parameter int          SAT_MAX   = SAT_MAX_DEF,
    parameter int          SAT_MIN   = SAT_MIN_DEF
) (
    input  logic signed [NB_INPUT-1:0]  in_data,
    output logic signed [NB_OUTPUT-1:0] out_data,
    output logic                        sat
);

    localparam int unsigned S = NB_INPUT - NB_OUTPUT;

    logic signed [NB_INPUT:0]  wide;
    logic signed [NB_OUTPUT:0] shifted;

    always_comb begin
        // One guard bit keeps the rounding add from wrapping at the positive limit.
        wide = {in_data[NB_INPUT-1], in_data};
`ifdef FIR_DEC_ROUND_EN
        wide = wide + ((NB_INPUT + 1)'(1) << (S - 1));
`endif
        shifted  = (NB_OUTPUT + 1)'(wide >>> S);
        sat      = 1'b0;
        out_data = shifted[NB_OUTPUT-1:0];
        if (shifted > SAT_MAX) begin
            out_data = NB_OUTPUT'(SAT_MAX);
            sat      = 1'b1;
        end else if (shifted < SAT_MIN) begin
            out_data = NB_OUTPUT'(SAT_MIN);
            sat      = 1'b1;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Decimates the FIR output by DEC_FACTOR, requantizes kept samples and buffers them in a
// 2-entry FIFO toward a ready/valid consumer. FIR_DEC_ROUND_EN selects round half-up.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int unsigned NB_INPUT   = NB_INPUT_DEF,
    parameter int unsigned NB_OUTPUT  = NB_OUTPUT_DEF,
    parameter int unsigned DEC_FACTOR = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [NB_INPUT-1:0]  in_data,
    input  logic                        in_valid,
    output logic signed [NB_OUTPUT-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic                        sat_flag
);

    localparam int unsigned PW      = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
    localparam int          SAT_MAX = int'(2 ** (NB_OUTPUT - 1)) - 1;
    localparam int          SAT_MIN = -SAT_MAX - 1;

    logic [PW-1:0]                phase_q, phase_d;
    logic                         keep;
    logic signed [NB_OUTPUT-1:0]  rq_data;
    logic                         rq_sat;
    logic                         stage_valid_q;
    logic signed [NB_OUTPUT-1:0]  stage_data_q;
    logic signed [NB_OUTPUT-1:0]  mem_q [FIFO_DEPTH];
    logic                         wr_ptr_q, rd_ptr_q;
    logic [1:0]                   count_q, count_d;
    logic signed [NB_OUTPUT-1:0]  last_q;
    logic                         overflow_q, sat_q;
    logic                         full, empty, push, pop;

    fir_sat_round #(
        .NB_INPUT  (NB_INPUT),
        .NB_OUTPUT (NB_OUTPUT),
        .SAT_MAX   (SAT_MAX),
        .SAT_MIN   (SAT_MIN)
    ) u_sat_round (
        .in_data  (in_data),
        .out_data (rq_data),
        .sat      (rq_sat)
    );

    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            if (phase_q == PW'(DEC_FACTOR - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        keep  = in_valid && (phase_q == '0);
        full  = (count_q == 2'(FIFO_DEPTH));
        empty = (count_q == 2'd0);
        pop   = out_ready && !empty;
        // A full FIFO still takes a write when the head leaves in the same cycle.
        push  = stage_valid_q && (!full || pop);
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            last_q     <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_valid_q <= keep;
            if (keep) begin
                stage_data_q <= rq_data;
            end
            if (keep && rq_sat) begin
                sat_q <= 1'b1;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= stage_data_q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                last_q   <= mem_q[rd_ptr_q];
            end
            if (stage_valid_q && !push) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    // While empty the output repeats the most recently popped sample.
    assign out_data  = empty ? last_q : mem_q[rd_ptr_q];
    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: one instance with R=1, one with R=4.
module tb_fir_out_decimator;

`ifdef FIR_DEC_ROUND_EN
    localparam logic signed [7:0] EXP24   = 8'sd2;
    localparam logic              EXP_SAT = 1'b1;
`else
    localparam logic signed [7:0] EXP24   = 8'sd1;
    localparam logic              EXP_SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst1, iv1, or1, ov1, of1, sf1;
    logic signed [11:0] id1;
    logic signed [7:0]  od1;
    logic               rst4, iv4, or4, ov4, of4, sf4;
    logic signed [11:0] id4;
    logic signed [7:0]  od4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fir_out_decimator #(.NB_INPUT(12), .NB_OUTPUT(8), .DEC_FACTOR(1)) dut1 (
        .clk(clk), .rst(rst1), .in_data(id1), .in_valid(iv1), .out_data(od1),
        .out_valid(ov1), .out_ready(or1), .overflow(of1), .sat_flag(sf1)
    );

    fir_out_decimator #(.NB_INPUT(12), .NB_OUTPUT(8), .DEC_FACTOR(4)) dut4 (
        .clk(clk), .rst(rst4), .in_data(id4), .in_valid(iv4), .out_data(od4),
        .out_valid(ov4), .out_ready(or4), .overflow(of4), .sat_flag(sf4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        rst1 = 1'b1; iv1 = 1'b0; id1 = '0; or1 = 1'b1;
        step();
        rst1 = 1'b0;
    endtask

    task automatic reset4();
        rst4 = 1'b1; iv4 = 1'b0; id4 = '0; or4 = 1'b1;
        step();
        rst4 = 1'b0;
    endtask

    task automatic test_reset();
        reset1();
        reset4();
        total_cnt++; if (ov1 !== 1'b0) $display("FAIL reset_valid1: got %b expected 0", ov1); else pass_cnt++;
        total_cnt++; if (od1 !== 8'sd0) $display("FAIL reset_data1: got %0d expected 0", od1); else pass_cnt++;
        total_cnt++; if (of1 !== 1'b0 || sf1 !== 1'b0) $display("FAIL reset_flags1: got %b%b expected 00", of1, sf1); else pass_cnt++;
        total_cnt++; if (ov4 !== 1'b0 || od4 !== 8'sd0) $display("FAIL reset4: got valid=%b data=%0d expected 0/0", ov4, od4); else pass_cnt++;
    endtask

    // R=4, 100 then zeros: kept 6 two cycles later, next kept phase gives 0.
    task automatic test_decimate();
        reset4();
        iv4 = 1'b1; id4 = 12'sd100;
        step();
        id4 = 12'sd0;
        step();
        total_cnt++; if (ov4 !== 1'b1 || od4 !== 8'sd6) $display("FAIL dec_first: got valid=%b data=%0d expected 1/6", ov4, od4); else pass_cnt++;
        step();
        total_cnt++; if (ov4 !== 1'b0 || od4 !== 8'sd6) $display("FAIL dec_hold: got valid=%b data=%0d expected 0/6", ov4, od4); else pass_cnt++;
        step();
        step();
        total_cnt++; if (ov4 !== 1'b0) $display("FAIL dec_discard: got valid=%b expected 0", ov4); else pass_cnt++;
        step();
        total_cnt++; if (ov4 !== 1'b1 || od4 !== 8'sd0) $display("FAIL dec_second: got valid=%b data=%0d expected 1/0", ov4, od4); else pass_cnt++;
        iv4 = 1'b0;
    endtask

    task automatic test_round();
        reset1();
        iv1 = 1'b1; id1 = 12'sd24;
        step();
        iv1 = 1'b0;
        step();
        total_cnt++; if (ov1 !== 1'b1 || od1 !== EXP24) $display("FAIL round24: got valid=%b data=%0d expected 1/%0d", ov1, od1, EXP24); else pass_cnt++;
    endtask

    task automatic test_saturate();
        reset1();
        iv1 = 1'b1; id1 = 12'sd2047;
        step();
        id1 = -12'sd2048;
        step();
        iv1 = 1'b0;
        total_cnt++; if (od1 !== 8'sd127) $display("FAIL sat_pos: got %0d expected 127", od1); else pass_cnt++;
        total_cnt++; if (sf1 !== EXP_SAT) $display("FAIL sat_flag: got %b expected %b", sf1, EXP_SAT); else pass_cnt++;
        step();
        total_cnt++; if (ov1 !== 1'b1 || od1 !== -8'sd128) $display("FAIL sat_neg: got valid=%b data=%0d expected 1/-128", ov1, od1); else pass_cnt++;
    endtask

    // Five inputs into a stalled consumer: two buffered, the rest overflow.
    task automatic test_overflow();
        reset1();
        or1 = 1'b0; iv1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            id1 = 12'(16 * k);
            step();
            if (k == 3) begin
                total_cnt++; if (of1 !== 1'b0) $display("FAIL ovf_early: got %b expected 0", of1); else pass_cnt++;
            end
        end
        iv1 = 1'b0;
        step();
        total_cnt++; if (of1 !== 1'b1) $display("FAIL ovf_set: got %b expected 1", of1); else pass_cnt++;
        total_cnt++; if (ov1 !== 1'b1 || od1 !== 8'sd1) $display("FAIL ovf_hold: got valid=%b data=%0d expected 1/1", ov1, od1); else pass_cnt++;
        or1 = 1'b1;
        step();
        total_cnt++; if (ov1 !== 1'b1 || od1 !== 8'sd2) $display("FAIL ovf_drain2: got valid=%b data=%0d expected 1/2", ov1, od1); else pass_cnt++;
        step();
        total_cnt++; if (ov1 !== 1'b0 || od1 !== 8'sd2) $display("FAIL ovf_empty: got valid=%b data=%0d expected 0/2", ov1, od1); else pass_cnt++;
    endtask

    // Full FIFO with a ready consumer and a continuous stream.
    task automatic test_back_to_back();
        reset1();
        or1 = 1'b0; iv1 = 1'b1; id1 = 12'sd16;
        for (int j = 1; j <= 7; j++) begin
            step();
            id1 = 12'(16 * (j + 1));
            if (j == 3) or1 = 1'b1;
            if (j >= 4) begin
                total_cnt++; if (ov1 !== 1'b1 || od1 !== 8'(j - 2) || of1 !== 1'b0) $display("FAIL b2b_%0d: got valid=%b data=%0d ovf=%b expected 1/%0d/0", j, ov1, od1, of1, j - 2); else pass_cnt++;
            end
        end
        iv1 = 1'b0;
        step();
        total_cnt++; if (ov1 !== 1'b1 || od1 !== 8'sd6) $display("FAIL b2b_tail6: got valid=%b data=%0d expected 1/6", ov1, od1); else pass_cnt++;
        step();
        total_cnt++; if (ov1 !== 1'b1 || od1 !== 8'sd7) $display("FAIL b2b_tail7: got valid=%b data=%0d expected 1/7", ov1, od1); else pass_cnt++;
        step();
        total_cnt++; if (ov1 !== 1'b0) $display("FAIL b2b_empty: got valid=%b expected 0", ov1); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        reset1();
        or1 = 1'b0; iv1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            id1 = 12'(16 * k);
            step();
        end
        total_cnt++; if (of1 !== 1'b1 || ov1 !== 1'b1) $display("FAIL mid_pre: got ovf=%b valid=%b expected 1/1", of1, ov1); else pass_cnt++;
        rst1 = 1'b1;
        step();
        rst1 = 1'b0; id1 = 12'sd80;
        total_cnt++; if (ov1 !== 1'b0 || od1 !== 8'sd0 || of1 !== 1'b0 || sf1 !== 1'b0) $display("FAIL mid_clear: got valid=%b data=%0d ovf=%b sat=%b expected 0/0/0/0", ov1, od1, of1, sf1); else pass_cnt++;
        iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        total_cnt++; if (ov1 !== 1'b0) $display("FAIL mid_inflight: got valid=%b expected 0", ov1); else pass_cnt++;
        step();
        total_cnt++; if (ov1 !== 1'b1 || od1 !== 8'sd5) $display("FAIL mid_first: got valid=%b data=%0d expected 1/5", ov1, od1); else pass_cnt++;

        // R=4: reset while the phase is nonzero; the first sample after it must be kept.
        reset4();
        iv4 = 1'b1; id4 = 12'sd0;
        step();
        step();
        rst4 = 1'b1;
        step();
        rst4 = 1'b0; id4 = 12'sd100;
        total_cnt++; if (ov4 !== 1'b0) $display("FAIL mid4_clear: got valid=%b expected 0", ov4); else pass_cnt++;
        step();
        id4 = 12'sd0;
        step();
        total_cnt++; if (ov4 !== 1'b1 || od4 !== 8'sd6) $display("FAIL mid4_phase0: got valid=%b data=%0d expected 1/6", ov4, od4); else pass_cnt++;
        iv4 = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
        rst4 = 1'b1; iv4 = 1'b0; id4 = '0; or4 = 1'b0;
        test_reset();
        test_decimate();
        test_round();
        test_saturate();
        test_overflow();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fir_out_decimator.md
FIR_OUT_DECIMATOR -- requirements
Module: fir_out_decimator

Interface
REQ-001 Parameter NB_INPUT, default 12, width of the signed FIR output consumed.
REQ-002 Parameter NB_OUTPUT, default 8, width of the signed requantized output.
REQ-003 Parameter DEC_FACTOR, default 4, decimation ratio R; legal range 1..16.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  NB_INPUT  signed sample from the FIR stage.
REQ-007 in_valid  input  1  in_data is valid this cycle; there is no backpressure toward the FIR.
REQ-008 out_data  output  NB_OUTPUT  signed requantized, decimated sample.
REQ-009 out_valid  output  1  out_data holds a sample.
REQ-010 out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
REQ-011 overflow  output  1  sticky flag: a kept sample was dropped because the buffer was full.
REQ-012 sat_flag  output  1  sticky flag: at least one kept sample was saturated.

Function
REQ-013 Phase counter: 0..R-1, advances only on in_valid, wraps R-1 -> 0; when R=1 it stays at 0.
REQ-014 Keep rule: a sample is kept when in_valid=1 and the phase is 0; all other samples are discarded.
REQ-015 Requantization: drop the S = NB_INPUT-NB_OUTPUT LSBs, with rounding per REQ-024/025, then saturate to [-2^(NB_OUTPUT-1), 2^(NB_OUTPUT-1)-1].
REQ-016 Arithmetic: the rounding add is done at NB_INPUT+1 bits, so no intermediate wrap occurs.
REQ-017 Buffer: a 2-entry FIFO sits after requantization; a kept sample is written on the cycle after it is accepted at the input (one register stage).
REQ-018 Latency: when the FIFO is empty, the kept sample appears on out_data with out_valid=1 two cycles after the in_valid edge.
REQ-019 Ordering: output order equals input order; out_data is stable while out_valid=1 and out_ready=0.
REQ-020 Full case: a write to a full FIFO with no simultaneous pop is discarded and sets overflow; the FIFO contents are unchanged.
REQ-021 Simultaneous push and pop: when the FIFO is full, the push and pop succeed together, the count is unchanged, and overflow is not set.
REQ-022 Empty case: out_valid=0, out_data is held at its last value, and out_ready is ignored.

Reset
REQ-023 rst=1 at a clock edge clears the phase counter, the pipeline register, the FIFO pointers and count, out_valid, out_data (to 0), overflow and sat_flag, and discards any in-flight sample; on the first edge with rst=0 the input is sampled at phase 0.

Configuration
REQ-024 With FIR_DEC_ROUND_EN defined: round half-up, i.e. add 2^(S-1) before the arithmetic right shift by S.
REQ-025 Without FIR_DEC_ROUND_EN: plain arithmetic right shift by S (truncation toward minus infinity); saturation logic is still present.

Structure
REQ-026 Shared package fir_pkg holds the NB_INPUT/NB_OUTPUT defaults, the saturation bound constants and the FIFO depth constant (2); the FIR stage uses the same package.
REQ-027 Sub-module fir_sat_round holds the combinational round and saturate logic plus its saturation indication; the FIFO and phase counter stay in the top level.

Verification
REQ-028 R=4, in_valid=1 continuously, in_data = 100 then 0s, out_ready=1 -> a single kept output of 6, two cycles after the input; 0 on the next kept phase.
REQ-029 R=1, in_data=24 -> out_data=2 with FIR_DEC_ROUND_EN defined; out_data=1 without it.
REQ-030 R=1, in_data=2047 then -2048 -> 127 with sat_flag=1 (rounded case), then -128.
REQ-031 R=1, out_ready=0 for 5 input cycles -> the first two samples are buffered, overflow=1 from the third write, and out_data holds the first sample; out_ready=1 then drains the two samples in order.
REQ-032 FIFO full and out_ready=1 with a continuous stream -> one pop and one push per cycle, count stays 2, overflow remains 0.
REQ-033 rst asserted for 1 cycle mid-stream with 2 entries buffered -> the next cycle has out_valid=0, flags=0, phase=0, and the first post-reset sample is kept.
